// File: rtl/fir_mac_serial.sv
// fir_mac_serial: time-multiplexed FIR, one tap per cycle, shadow/active coefficient banks.
// Define FIR_MAC_SAT_EN to saturate the output and add the sat_flag port.
module fir_mac_serial #(
    parameter int NTAPS  = 21,
    parameter int DIN_W  = 14,
    parameter int COEF_W = 10,
    parameter int DOUT_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic [DIN_W-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DOUT_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              coef_we,
    input  logic [5:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    input  logic              coef_commit,
`ifdef FIR_MAC_SAT_EN
    output logic              sat_flag,
`endif
    output logic              busy
);
    localparam int KW = $clog2(NTAPS);
    localparam int PW = DIN_W + COEF_W;
    localparam int AW = PW + $clog2(NTAPS);
    localparam int F  = COEF_W - 1;
`ifdef FIR_MAC_SAT_EN
    localparam int QW = AW - F + 1;
`else
    localparam int QW = DOUT_W;
`endif
    localparam logic [F-1:0] HALF = F'(1) << (F - 1);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                   r_state;
    logic signed [DIN_W-1:0]  r_delay  [NTAPS];
    logic signed [COEF_W-1:0] r_shadow [NTAPS];
    logic signed [COEF_W-1:0] r_active [NTAPS];
    logic signed [AW-1:0]     r_acc;
    logic [KW-1:0]            r_k;
    logic                     r_pending;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic                     r_busy;
    logic [DOUT_W-1:0]        r_out_data;

    logic signed [PW-1:0]     w_prod;
    logic signed [AW-1:0]     w_sum;
    logic [QW-1:0]            w_q;
    logic                     w_up;
    logic [DOUT_W-1:0]        w_res;
`ifdef FIR_MAC_SAT_EN
    logic                     w_ovf;
    logic                     r_sat;
    assign sat_flag = r_sat;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_busy;

    // Round half to even when dropping the F coefficient fraction bits.
    always_comb begin
        w_prod = PW'(r_delay[r_k]) * PW'(r_active[r_k]);
        w_sum  = r_acc + AW'(w_prod);
        w_up   = (w_sum[F-1:0] > HALF) || (w_sum[F-1:0] == HALF && w_sum[F]);
        w_q    = QW'(w_sum >>> F) + QW'(w_up);
`ifdef FIR_MAC_SAT_EN
        w_ovf  = !((&w_q[QW-1:DOUT_W-1]) || !(|w_q[QW-1:DOUT_W-1]));
        w_res  = w_ovf ? {w_q[QW-1], {(DOUT_W-1){!w_q[QW-1]}}} : w_q[DOUT_W-1:0];
`else
        w_res  = w_q[DOUT_W-1:0];
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_delay[i]  <= '0;
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
            r_acc       <= '0;
            r_k         <= '0;
            r_state     <= IDLE;
            r_pending   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_out_data  <= '0;
`ifdef FIR_MAC_SAT_EN
            r_sat       <= 1'b0;
`endif
        end else if (ce) begin
            if (coef_we && {1'b0, coef_addr} < 7'(NTAPS))
                r_shadow[coef_addr[KW-1:0]] <= coef_data;
            unique case (r_state)
                IDLE: begin
                    if (r_pending) begin
                        r_active   <= r_shadow;
                        r_pending  <= 1'b0;
                        r_in_ready <= 1'b1;
                    end else if (in_valid) begin
                        r_delay[0] <= in_data;
                        for (int i = 1; i < NTAPS; i++)
                            r_delay[i] <= r_delay[i-1];
                        r_acc      <= '0;
                        r_k        <= '0;
                        r_state    <= MAC;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        // The accepted sample keeps the old bank; a same-edge commit waits.
                        r_pending  <= coef_commit;
                    end else if (coef_commit) begin
                        r_active <= r_shadow;
                    end
                end
                MAC: begin
                    r_acc <= w_sum;
                    r_k   <= r_k + KW'(1);
                    if (coef_commit)
                        r_pending <= 1'b1;
                    if (r_k == KW'(NTAPS - 1)) begin
                        r_out_data  <= w_res;
`ifdef FIR_MAC_SAT_EN
                        r_sat       <= w_ovf;
`endif
                        r_out_valid <= 1'b1;
                        r_state     <= OUT;
                    end
                end
                OUT: begin
                    if (coef_commit)
                        r_pending <= 1'b1;
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= !(r_pending || coef_commit);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_mac_serial.sv
// tb_fir_mac_serial: directed vectors for fir_mac_serial against a transaction-level model.
// Honours FIR_MAC_SAT_EN when the design is built with it.
module tb_fir_mac_serial;
    localparam int NTAPS  = 21;
    localparam int DIN_W  = 14;
    localparam int COEF_W = 10;
    localparam int DOUT_W = 14;
    localparam longint SCALE = longint'(1) << (COEF_W - 1);
    localparam longint LIM   = longint'(1) << (DOUT_W - 1);

    logic clk = 0, reset = 0, ce = 1, in_valid = 0, out_ready = 0, coef_we = 0, coef_commit = 0;
    logic [DIN_W-1:0]  in_data   = '0;
    logic [5:0]        coef_addr = '0;
    logic [COEF_W-1:0] coef_data = '0;
    logic              in_ready, out_valid, busy;
    logic [DOUT_W-1:0] out_data;
`ifdef FIR_MAC_SAT_EN
    logic              sat_flag;
`endif

    int     n_cmp = 0, n_bad = 0;
    int     sh[NTAPS], act[NTAPS], hist[NTAPS];
    bit     m_busy = 0, m_pending = 0, m_sat = 0;
    longint m_tick = 0, m_due = 0;
    int     m_exp = 0;

    always #5 clk = ~clk;

    fir_mac_serial #(.NTAPS(NTAPS), .DIN_W(DIN_W), .COEF_W(COEF_W), .DOUT_W(DOUT_W)) dut (
        .clk(clk), .reset(reset), .ce(ce),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_commit(coef_commit),
`ifdef FIR_MAC_SAT_EN
        .sat_flag(sat_flag),
`endif
        .busy(busy)
    );

    task automatic chk(string name, longint got, longint want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, got, want, $time);
        end
    endtask

    function automatic int model_out(output bit sat);
        longint s = 0, r, q;
        for (int k = 0; k < NTAPS; k++) s += longint'(hist[k]) * act[k];
        r = s % SCALE;
        if (r < 0) r += SCALE;
        q = (s - r) / SCALE;
        if (r > SCALE / 2 || (r == SCALE / 2 && q % 2 != 0)) q++;
        sat = 0;
`ifdef FIR_MAC_SAT_EN
        if (q > LIM - 1) begin q = LIM - 1; sat = 1; end
        else if (q < -LIM) begin q = -LIM; sat = 1; end
`else
        q = q % (2 * LIM);
        if (q < 0) q += 2 * LIM;
        if (q >= LIM) q -= 2 * LIM;
`endif
        return int'(q);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NTAPS; k++) begin sh[k] = 0; act[k] = 0; hist[k] = 0; end
        m_busy = 0;
        m_pending = 0;
    endtask

    // Model advances on every enabled edge using the values present before the edge.
    always @(posedge clk) begin
        bit pre_idle, pre_outv, take;
        if (!reset && ce) begin
            pre_idle = !m_busy;
            pre_outv = m_busy && m_tick >= m_due;
            take     = pre_idle && !m_pending && in_valid;
            m_tick++;
            if (pre_idle) begin
                if (m_pending) begin act = sh; m_pending = 0; end
                else if (coef_commit && take) m_pending = 1;
                else if (coef_commit) act = sh;
                if (take) begin
                    for (int k = NTAPS - 1; k > 0; k--) hist[k] = hist[k-1];
                    hist[0] = int'($signed(in_data));
                    m_exp  = model_out(m_sat);
                    m_busy = 1;
                    m_due  = m_tick + NTAPS;
                end
            end else begin
                if (coef_commit) m_pending = 1;
                if (pre_outv && out_ready) m_busy = 0;
            end
            if (coef_we && coef_addr < NTAPS) sh[coef_addr] = int'($signed(coef_data));
        end
    end

    always @(posedge clk) begin
        bit ev;
        #2;
        if (!reset) begin
            ev = m_busy && m_tick >= m_due;
            chk("in_ready", in_ready, !m_busy && !m_pending);
            chk("busy", busy, m_busy);
            chk("out_valid", out_valid, ev);
            if (ev) begin
                chk("out_data", $signed(out_data), m_exp);
`ifdef FIR_MAC_SAT_EN
                chk("sat_flag", sat_flag, m_sat);
`endif
            end
        end
    end

    task automatic write_coef(int addr, int val);
        coef_we = 1; coef_addr = 6'(addr); coef_data = COEF_W'(val);
        @(negedge clk);
        coef_we = 0;
    endtask

    task automatic commit();
        coef_commit = 1;
        @(negedge clk);
        coef_commit = 0;
    endtask

    // mode: 0 plain, 1 ce gap, 2 coef write+commit mid-MAC, 3 same then reset at tap 10
    task automatic send(int sample, bit lit_en, int lit, int out_wait, int mode);
        int c = 0, n = 0;
        in_data = DIN_W'(sample);
        in_valid = 1;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        chk("accept_wait", n < 100, 1);
        @(negedge clk);
        in_valid = 0;
        while (!out_valid && c < 200 && !(mode == 3 && c == 10)) begin
            @(negedge clk);
            c++;
            if (mode == 1) ce = !(c >= 5 && c < 8);
            if (mode >= 2) begin
                coef_addr = 0; coef_data = 10'h100;
                coef_we = (c == 5); coef_commit = (c == 6);
            end
        end
        if (mode == 3) begin
            reset = 1;
            model_reset();
            #1;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_data", out_data, 0);
            chk("rst_busy", busy, 0);
            @(negedge clk);
            reset = 0;
            return;
        end
        chk("latency", c, NTAPS + (mode == 1 ? 3 : 0));
        if (lit_en) chk("out_lit", $signed(out_data), lit);
        repeat (out_wait) begin
            @(negedge clk);
            if (lit_en) chk("hold_data", $signed(out_data), lit);
            chk("hold_valid", out_valid, 1);
            chk("hold_ready", in_ready, 0);
        end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("done_valid", out_valid, 0);
        if (mode == 2) begin
            chk("commit_gap", in_ready, 0);
            @(negedge clk);
            chk("commit_resume", in_ready, 1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_out_data", out_data, 0);
        write_coef(0, 'h100);
        commit();
        send('h1000, 1, 'h800, 0, 0);
        write_coef(0, 1);
        write_coef(32, 'h1FF);
        write_coef(63, 'h1FF);
        commit();
        send('h100, 1, 0, 0, 0);
        send('h300, 1, 2, 5, 0);
        send('h500, 1, 2, 0, 1);
        send(-'h100, 1, 0, 0, 0);
        send(-'h300, 1, -2, 0, 0);
        send(-'h500, 1, -2, 0, 0);
        send('h300, 1, 2, 0, 2);
        send('h300, 1, 384, 0, 0);
        for (int i = 0; i < NTAPS; i++) write_coef(i, 'h1FF);
        commit();
        for (int i = 0; i < NTAPS; i++)
`ifdef FIR_MAC_SAT_EN
            send('h1FFF, i == NTAPS - 1, 8191, 0, 0);
`else
            send('h1FFF, i == NTAPS - 1, 7835, 0, 0);
`endif
        send('h1FFF, 0, 0, 0, 3);
        send('h1000, 1, 0, 0, 0);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
